// File: rtl/uart_frame_assembler_if.sv
// Byte-in / frame-out bundle between UART_RX, the frame assembler and its consumer.
interface uart_frame_assembler_if #(
  parameter int unsigned FFT_SIZE    = 16,
  parameter int unsigned WORD_SIZE   = 16,
  parameter int unsigned DATA_LENGTH = 8
);
  localparam int unsigned FRAME_W = FFT_SIZE * WORD_SIZE;

  logic [DATA_LENGTH-1:0] i_byte;
  logic                   i_byte_valid;
  logic                   i_frame_ack;
  logic [FRAME_W-1:0]     o_words;
  logic                   o_frame_valid;
  logic                   o_busy;
  logic                   o_timeout_err;
  logic                   o_overrun_err;

  // Producer/consumer side: supplies bytes and acks, observes the frame.
  modport master (
    output i_byte, i_byte_valid, i_frame_ack,
    input  o_words, o_frame_valid, o_busy, o_timeout_err, o_overrun_err
  );

  // Assembler side.
  modport slave (
    input  i_byte, i_byte_valid, i_frame_ack,
    output o_words, o_frame_valid, o_busy, o_timeout_err, o_overrun_err
  );
endinterface

// File: rtl/uart_frame_assembler.sv
// Reassembles a UART byte stream into FFT_SIZE words (low byte first) and
// presents each complete frame through a valid/ack double-buffered output.
module uart_frame_assembler #(
  parameter int unsigned FFT_SIZE       = 16,
  parameter int unsigned WORD_SIZE      = 16,
  parameter int unsigned DATA_LENGTH    = 8,
  parameter int unsigned TIMEOUT_CYCLES = 34720
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  uart_frame_assembler_if.slave   bus
);

  localparam int unsigned BPW         = WORD_SIZE / DATA_LENGTH;
  localparam int unsigned FRAME_BYTES = FFT_SIZE * BPW;
  localparam int unsigned FRAME_W     = FRAME_BYTES * DATA_LENGTH;
  localparam int unsigned IDX_W       = (FRAME_BYTES > 1) ? $clog2(FRAME_BYTES) : 1;
  localparam int unsigned IDLE_W      = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(FRAME_BYTES - 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic {
    IDLE,
    COLLECT
  } state_t;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [IDLE_W-1:0]   idle_q, idle_d;
  logic [FRAME_W-1:0]  asm_q, asm_d;
  logic                frame_done_c;
  logic                timeout_c;
  logic                load_c;
  logic                overrun_c;
  logic                valid_d;

  // Assembly FSM: byte placement, index/idle bookkeeping, completion and timeout.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    idle_d       = idle_q;
    asm_d        = asm_q;
    frame_done_c = 1'b0;
    timeout_c    = 1'b0;

    // Flat byte n lands at bit n*DATA_LENGTH, i.e. word n/BPW lane n%BPW.
    if (bus.i_byte_valid) begin
      for (int unsigned n = 0; n < FRAME_BYTES; n++) begin
        if (idx_q == IDX_W'(n)) asm_d[n*DATA_LENGTH +: DATA_LENGTH] = bus.i_byte;
      end
    end

    case (state_q)
      IDLE: begin
        if (bus.i_byte_valid) begin
          idle_d = '0;
          if (idx_q == LAST_IDX) begin
            frame_done_c = 1'b1;
            idx_d        = '0;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = COLLECT;
          end
        end
      end
      COLLECT: begin
        if (bus.i_byte_valid) begin
          idle_d = '0;
          if (idx_q == LAST_IDX) begin
            frame_done_c = 1'b1;
            idx_d        = '0;
            state_d      = IDLE;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end else if (idle_q == IDLE_LAST) begin
          timeout_c = 1'b1;
          idx_d     = '0;
          idle_d    = '0;
          state_d   = IDLE;
        end else begin
          idle_d = idle_q + IDLE_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output handshake: an ack frees the slot before a completing frame tries to load.
  always_comb begin
    load_c    = frame_done_c && (!bus.o_frame_valid || bus.i_frame_ack);
    overrun_c = frame_done_c && !load_c;
    valid_d   = bus.o_frame_valid;
    if (bus.i_frame_ack) valid_d = 1'b0;
    if (load_c)          valid_d = 1'b1;
    if (overrun_c)       valid_d = 1'b1;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      idle_q  <= '0;
      asm_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      idle_q  <= idle_d;
      asm_q   <= asm_d;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      bus.o_words       <= '0;
      bus.o_frame_valid <= 1'b0;
      bus.o_busy        <= 1'b0;
      bus.o_timeout_err <= 1'b0;
      bus.o_overrun_err <= 1'b0;
    end else begin
      if (load_c) bus.o_words <= asm_d;
      bus.o_frame_valid <= valid_d;
      bus.o_busy        <= (state_d == COLLECT);
      bus.o_timeout_err <= timeout_c;
      bus.o_overrun_err <= overrun_c;
    end
  end

endmodule

// File: tb/tb_uart_frame_assembler.sv
// Bench for uart_frame_assembler: vector table, hand-written corner sequences and
// random traffic, all checked cycle by cycle against a queue-based frame model.
module tb_uart_frame_assembler;

  localparam int FFT_SIZE    = 16;
  localparam int WORD_SIZE   = 16;
  localparam int DATA_LENGTH = 8;
  localparam int TIMEOUT     = 200;
  localparam int BPW         = WORD_SIZE / DATA_LENGTH;
  localparam int FRAME_BYTES = FFT_SIZE * BPW;
  localparam int FW          = FFT_SIZE * WORD_SIZE;

  logic clk;
  logic rst_n;

  uart_frame_assembler_if #(
    .FFT_SIZE(FFT_SIZE), .WORD_SIZE(WORD_SIZE), .DATA_LENGTH(DATA_LENGTH)
  ) bus ();

  uart_frame_assembler #(
    .FFT_SIZE(FFT_SIZE), .WORD_SIZE(WORD_SIZE), .DATA_LENGTH(DATA_LENGTH),
    .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int tout_seen = 0;
  int ovr_seen = 0;

  // Reference model state: bytes of the partial frame, clocks since the last byte,
  // and the frame currently presented.
  logic [7:0]    part[$];
  int            idle_clks;
  logic [FW-1:0] m_words;
  bit            m_valid, m_busy, m_tout, m_ovr;

  typedef struct {
    logic [7:0]  base;
    int          gap;
    logic [15:0] w0;
    logic [15:0] w1;
    logic [15:0] w15;
  } vec_t;

  task automatic chk(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    part.delete();
    idle_clks = 0;
    m_words   = '0;
    m_valid   = 1'b0;
    m_busy    = 1'b0;
    m_tout    = 1'b0;
    m_ovr     = 1'b0;
  endtask

  task automatic model_step(input bit bv, input logic [7:0] b, input bit ack);
    logic [FW-1:0] frame;
    bit done;
    done   = 1'b0;
    frame  = '0;
    m_tout = 1'b0;
    m_ovr  = 1'b0;
    if (bv) begin
      part.push_back(b);
      idle_clks = 0;
      if (part.size() == FRAME_BYTES) begin
        for (int n = 0; n < FRAME_BYTES; n++)
          frame[(n / BPW) * WORD_SIZE + (n % BPW) * DATA_LENGTH +: DATA_LENGTH] = part[n];
        part.delete();
        done = 1'b1;
      end
    end else if (part.size() != 0) begin
      idle_clks++;
      if (idle_clks == TIMEOUT) begin
        part.delete();
        idle_clks = 0;
        m_tout    = 1'b1;
      end
    end
    if (ack && m_valid) m_valid = 1'b0;
    if (done) begin
      if (!m_valid) begin
        m_words = frame;
        m_valid = 1'b1;
      end else begin
        m_ovr = 1'b1;
      end
    end
    m_busy = (part.size() != 0);
  endtask

  // One clock: drive inputs, let the edge happen, compare 1 time unit later.
  task automatic step(input bit bv, input logic [7:0] b, input bit ack);
    bus.i_byte_valid = bv;
    bus.i_byte       = b;
    bus.i_frame_ack  = ack;
    @(posedge clk);
    #1;
    model_step(bv, b, ack);
    chk("frame_valid", FW'(bus.o_frame_valid), FW'(m_valid));
    chk("busy",        FW'(bus.o_busy),        FW'(m_busy));
    chk("timeout_err", FW'(bus.o_timeout_err), FW'(m_tout));
    chk("overrun_err", FW'(bus.o_overrun_err), FW'(m_ovr));
    chk("words",       bus.o_words,            m_words);
    if (bus.o_timeout_err) tout_seen++;
    if (bus.o_overrun_err) ovr_seen++;
    bus.i_byte_valid = 1'b0;
    bus.i_frame_ack  = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] base, input int gap, input bit ack_last);
    for (int n = 0; n < FRAME_BYTES; n++) begin
      step(1'b1, base + 8'(n), ack_last && (n == FRAME_BYTES - 1));
      if (n < FRAME_BYTES - 1) repeat (gap) step(1'b0, 8'h00, 1'b0);
    end
  endtask

  task automatic release_output();
    if (bus.o_frame_valid) step(1'b0, 8'h00, 1'b1);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_words"}, bus.o_words, '0);
    chk({tag, "_valid"}, FW'(bus.o_frame_valid), '0);
    chk({tag, "_busy"},  FW'(bus.o_busy), '0);
    chk({tag, "_tout"},  FW'(bus.o_timeout_err), '0);
    chk({tag, "_ovr"},   FW'(bus.o_overrun_err), '0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[4];
    int   found;
    int   quiet;

    vecs[0] = '{base: 8'h00, gap: 20, w0: 16'h0100, w1: 16'h0302, w15: 16'h1F1E};
    vecs[1] = '{base: 8'hA0, gap: 1,  w0: 16'hA1A0, w1: 16'hA3A2, w15: 16'hBFBE};
    vecs[2] = '{base: 8'h40, gap: 3,  w0: 16'h4140, w1: 16'h4342, w15: 16'h5F5E};
    vecs[3] = '{base: 8'hF0, gap: 0,  w0: 16'hF1F0, w1: 16'hF3F2, w15: 16'h0F0E};

    bus.i_byte       = '0;
    bus.i_byte_valid = 1'b0;
    bus.i_frame_ack  = 1'b0;
    rst_n            = 1'b0;
    model_reset();
    #12;
    chk_outputs_zero("reset");
    rst_n = 1'b1;
    step(1'b0, 8'h00, 1'b0);

    // Vector table: one frame per record, then check word placement.
    for (int i = 0; i < 4; i++) begin
      release_output();
      send_frame(vecs[i].base, vecs[i].gap, 1'b0);
      chk("tbl_valid", FW'(bus.o_frame_valid), FW'(1));
      chk("tbl_w0",    FW'(bus.o_words[15:0]),    FW'(vecs[i].w0));
      chk("tbl_w1",    FW'(bus.o_words[31:16]),   FW'(vecs[i].w1));
      chk("tbl_w15",   FW'(bus.o_words[255:240]), FW'(vecs[i].w15));
      chk("tbl_busy",  FW'(bus.o_busy), '0);
    end
    release_output();

    // Partial frame then silence: exactly one timeout, TIMEOUT clocks after byte 5.
    tout_seen = 0;
    for (int n = 1; n <= 5; n++) step(1'b1, 8'(n), 1'b0);
    found = -1;
    for (int k = 1; k <= TIMEOUT + 10; k++) begin
      step(1'b0, 8'h00, 1'b0);
      if (bus.o_timeout_err) begin
        found = k;
        break;
      end
    end
    chk("tout_latency", FW'(found), FW'(TIMEOUT));
    repeat (5) step(1'b0, 8'h00, 1'b0);
    chk("tout_once", FW'(tout_seen), FW'(1));
    chk("tout_no_frame", FW'(bus.o_frame_valid), '0);
    send_frame(8'hA0, 0, 1'b0);
    chk("after_tout_w0", FW'(bus.o_words[15:0]), FW'(16'hA1A0));
    release_output();

    // A byte landing on the very edge the timeout would fire wins.
    tout_seen = 0;
    for (int n = 0; n < 3; n++) step(1'b1, 8'h30 + 8'(n), 1'b0);
    repeat (TIMEOUT - 1) step(1'b0, 8'h00, 1'b0);
    for (int n = 3; n < FRAME_BYTES; n++) step(1'b1, 8'h30 + 8'(n), 1'b0);
    chk("edge_no_tout", FW'(tout_seen), '0);
    chk("edge_valid",   FW'(bus.o_frame_valid), FW'(1));
    chk("edge_w0",      FW'(bus.o_words[15:0]),    FW'(16'h3130));
    chk("edge_w15",     FW'(bus.o_words[255:240]), FW'(16'h4F4E));
    release_output();

    // Overrun: A held, B dropped, then C after ack.
    send_frame(8'h10, 0, 1'b0);
    ovr_seen = 0;
    send_frame(8'h60, 1, 1'b0);
    chk("ovr_once",  FW'(ovr_seen), FW'(1));
    chk("ovr_keepA", FW'(bus.o_words[15:0]), FW'(16'h1110));
    step(1'b0, 8'h00, 1'b1);
    chk("ack_clears", FW'(bus.o_frame_valid), '0);
    send_frame(8'h80, 0, 1'b0);
    chk("c_w0", FW'(bus.o_words[15:0]), FW'(16'h8180));

    // Ack coinciding with the last byte of the next frame.
    ovr_seen = 0;
    send_frame(8'hC0, 0, 1'b1);
    chk("coin_valid", FW'(bus.o_frame_valid), FW'(1));
    chk("coin_w0",    FW'(bus.o_words[15:0]), FW'(16'hC1C0));
    chk("coin_noovr", FW'(ovr_seen), '0);

    // Asynchronous reset in the middle of a frame while a frame is presented.
    for (int n = 0; n < 10; n++) step(1'b1, 8'h20 + 8'(n), 1'b0);
    #3;
    rst_n = 1'b0;
    #1;
    chk_outputs_zero("async_rst");
    model_reset();
    #2;
    rst_n = 1'b1;
    step(1'b0, 8'h00, 1'b0);
    send_frame(8'h40, 0, 1'b0);
    chk("post_rst_w0", FW'(bus.o_words[15:0]), FW'(16'h4140));

    // Random traffic with occasional idle bursts straddling the timeout.
    quiet = 0;
    for (int c = 0; c < 4000; c++) begin
      bit         bv;
      bit         ack;
      logic [7:0] b;
      if (quiet > 0) begin
        quiet--;
        bv = 1'b0;
      end else begin
        bv = ($urandom_range(0, 2) == 0);
        if ($urandom_range(0, 199) == 0) quiet = int'($urandom_range(TIMEOUT - 2, TIMEOUT + 2));
      end
      b   = 8'($urandom);
      ack = ($urandom_range(0, 15) == 0);
      step(bv, b, ack);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_frame_assembler.md
# uart_frame_assembler

Receive-side frame builder for the FFT link. It takes the byte stream delivered by the UART receiver and reassembles it into FFT_SIZE words of WORD_SIZE bits, low byte first, which is the same byte order the FFT result transmitter uses on the outbound side. It presents one complete, stable frame to the downstream consumer with a valid/ack handshake. It sits between UART_RX and the frame consumer: host-side loopback checker, or a word-wide FFT input loader.

## Interface
- FFT_SIZE, 16, words per frame
- WORD_SIZE, 16, bits per word; must be an integer multiple of DATA_LENGTH
- DATA_LENGTH, 8, bits per UART byte
- TIMEOUT_CYCLES, 34720, idle clocks between bytes that abort a partial frame (40 bit times at 868 clocks per bit)
- Derived: BPW = WORD_SIZE/DATA_LENGTH; FRAME_BYTES = FFT_SIZE*BPW (32 by default)

Ports:
- i_clk  in  1  single clock
- i_rst_n  in  1  reset, asynchronous, active-low
- i_byte  in  DATA_LENGTH  received byte, valid only while i_byte_valid=1
- i_byte_valid  in  1  one-cycle strobe, one per received byte
- i_frame_ack  in  1  consumer releases the presented frame
- o_words  out  FFT_SIZE*WORD_SIZE  output frame; word k is at [k*WORD_SIZE +: WORD_SIZE]
- o_frame_valid  out  1  o_words holds a complete, unacknowledged frame
- o_busy  out  1  a partial frame is being collected
- o_timeout_err  out  1  one-cycle pulse when a partial frame is discarded on timeout
- o_overrun_err  out  1  one-cycle pulse when a completed frame is dropped because the output is still occupied

## Operation
- Buffers:
  - Assembly register: FRAME_BYTES bytes.
  - Output register: o_words.
  - Byte index: 0..FRAME_BYTES-1.
  - Idle counter: $clog2(TIMEOUT_CYCLES) bits.
- Byte placement: byte n goes to word n/BPW, lane n%BPW. Lane 0 maps to word bits [DATA_LENGTH-1:0].
- Assembly FSM:
  - IDLE: index=0 and o_busy=0.
    - i_byte_valid=1: store the byte at index 0, set index=1, clear the idle counter, go to COLLECT.
  - COLLECT: o_busy=1.
    - Each i_byte_valid=1 stores the byte, increments the index and clears the idle counter.
    - Cycles without a byte increment the idle counter.
    - Last byte (index=FRAME_BYTES-1 with i_byte_valid): the completed frame is offered to the output register, index returns to 0, go to IDLE.
    - Idle counter reaches TIMEOUT_CYCLES-1 with no byte that cycle: drop the partial frame, set index=0, pulse o_timeout_err, go to IDLE.
    - A byte and the timeout in the same cycle: the byte wins and no timeout occurs.
- Output handshake, evaluated in this order on every cycle:
  - i_frame_ack with o_frame_valid=1 frees the output.
  - A completed frame loads into o_words and sets o_frame_valid=1 if the output is free after that ack. Otherwise the new frame is discarded, o_overrun_err pulses, and o_words is left unchanged.
  - i_frame_ack while o_frame_valid=0 is ignored.
- Collection of the next frame continues while o_frame_valid=1. This gives double buffering.
- The assembly register is not cleared between frames. Every byte is overwritten before a frame completes.

## Timing
- Reset (async assert, sync release): o_words=0, o_frame_valid=0, o_busy=0, o_timeout_err=0, o_overrun_err=0, index=0, idle counter=0, FSM=IDLE.
- Reset mid-frame drops the partial frame and the presented frame. No error pulse is produced.
- Load latency: the last byte is sampled on edge E. o_words and o_frame_valid=1 are visible after edge E; there is no additional delay.
- Release latency: i_frame_ack is sampled on edge E. o_frame_valid=0 after edge E, unless a new frame completes on that same edge, in which case it stays 1 with the new data.
- o_busy rises after the edge that samples the first byte. It falls after the edge that samples the last byte, or after the timeout edge.
- Both error pulses are exactly one cycle wide and registered.
- Timeout fires exactly TIMEOUT_CYCLES clocks after the last accepted byte, provided no other byte arrives.
- o_words changes only on a frame load or on reset.

## Test plan
- Send 32 bytes 0x00..0x1F, 20 cycles apart. Required: o_frame_valid rises after the 32nd byte; word0=0x0100, word1=0x0302, word15=0x1F1E; o_busy=0 afterwards.
- Send 5 bytes, then stay idle. Required: o_timeout_err pulses once, TIMEOUT_CYCLES clocks after byte 5; o_frame_valid stays 0. Then send 32 bytes 0xA0..0xBF. Required: word0=0xA1A0.
- Edge case: a byte arrives exactly on the cycle the timeout would fire. Required: no o_timeout_err; the frame completes normally.
- Frame A is valid and not acked; send frame B (32 bytes). Required: o_overrun_err pulses once and o_words still holds A. Then ack, and send frame C. Required: C is presented.
- Frame A is valid; the 32nd byte of frame B and i_frame_ack coincide on the same edge. Required: o_frame_valid stays 1, o_words=B, no overrun.
- Assert i_rst_n=0 after 10 bytes, asynchronously mid-cycle. Required: all outputs are 0 immediately. After release, send 32 bytes 0x40..0x5F. Required: word0=0x4140.
